// File: rtl/inv_arbiter.sv
// inv_arbiter: shares one Montgomery inverter between two requesters (A, B).
// Accepts one request at a time with round-robin tie breaking, holds the
// accepted operands for the whole inversion, drives the inverter's request
// and result handshakes and returns the result to the port that asked.
// Also produces the inverter's synchronous active-high reset.
module inv_arbiter #(
    parameter int N = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    // requester A
    input  logic [N-1:0] X_a,
    input  logic [N-1:0] M_a,
    input  logic         real_a,
    input  logic         req_valid_a,
    output logic         req_ready_a,
    // requester B
    input  logic [N-1:0] X_b,
    input  logic [N-1:0] M_b,
    input  logic         real_b,
    input  logic         req_valid_b,
    output logic         req_ready_b,
    // shared result
    output logic [N-1:0] R,
    output logic         res_err,
    output logic         res_valid_a,
    output logic         res_valid_b,
    input  logic         res_ready_a,
    input  logic         res_ready_b,
    // status
    output logic         busy,
    output logic         owner,
    // inverter side
    output logic         inv_rst,
    output logic [N-1:0] inv_X,
    output logic [N-1:0] inv_M,
    output logic         inv_real,
    output logic         inv_req_valid,
    input  logic         inv_req_ready,
    input  logic         inv_req_busy,
    input  logic         inv_res_valid,
    output logic         inv_res_ready,
    input  logic [N-1:0] inv_R
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    // An operand of zero has no inverse; it is answered locally with an error.
    function automatic logic is_zero(input logic [N-1:0] v);
        return (v == {N{1'b0}});
    endfunction

    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic [N-1:0] r_q, r_d;
    logic         err_q, err_d;
    logic [N-1:0] x_q, x_d;
    logic [N-1:0] m_q, m_d;
    logic         real_q, real_d;
    logic         res_rdy_q, res_rdy_d;
    logic         rst_sync_q;
    logic         inv_rst_q;

    logic         can_grant_s;
    logic         gnt_a_s;
    logic         gnt_b_s;
    logic         accept_s;
    logic [N-1:0] sel_x_s;
    logic [N-1:0] sel_m_s;
    logic         sel_real_s;
    logic         owner_ready_s;

    // Inverter reset: asserted asynchronously with rst_n, released on the
    // second rising edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
            inv_rst_q  <= 1'b1;
        end else begin
            rst_sync_q <= 1'b1;
            inv_rst_q  <= ~rst_sync_q;
        end
    end

    // Grant decision: only in IDLE, never while the inverter is held in reset
    // or still reports busy (stale inverter); ties go to the port that was
    // not the previous owner.
    always_comb begin
        can_grant_s = 1'b0;
        gnt_a_s     = 1'b0;
        gnt_b_s     = 1'b0;
        if ((state_q == ST_IDLE) && !inv_rst_q && !inv_req_busy) begin
            can_grant_s = 1'b1;
        end else begin
            can_grant_s = 1'b0;
        end
        if (can_grant_s) begin
            gnt_a_s = req_valid_a & (~req_valid_b | owner_q);
            gnt_b_s = req_valid_b & (~req_valid_a | ~owner_q);
        end else begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end
    end

    // Operand selection for the granted port and result-consumer selection.
    always_comb begin
        sel_x_s       = X_a;
        sel_m_s       = M_a;
        sel_real_s    = real_a;
        owner_ready_s = res_ready_a;
        if (gnt_b_s) begin
            sel_x_s    = X_b;
            sel_m_s    = M_b;
            sel_real_s = real_b;
        end else begin
            sel_x_s    = X_a;
            sel_m_s    = M_a;
            sel_real_s = real_a;
        end
        if (owner_q) begin
            owner_ready_s = res_ready_b;
        end else begin
            owner_ready_s = res_ready_a;
        end
    end

    assign accept_s = gnt_a_s | gnt_b_s;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        r_d       = r_q;
        err_d     = err_q;
        x_d       = x_q;
        m_d       = m_q;
        real_d    = real_q;
        res_rdy_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    x_d     = sel_x_s;
                    m_d     = sel_m_s;
                    real_d  = sel_real_s;
                    owner_d = gnt_b_s;
                    if (is_zero(sel_x_s)) begin
                        r_d     = {N{1'b0}};
                        err_d   = 1'b1;
                        state_d = ST_DELIVER;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (inv_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (inv_res_valid) begin
                    r_d       = inv_R;
                    err_d     = 1'b0;
                    res_rdy_d = 1'b1;
                    state_d   = ST_DELIVER;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DELIVER: begin
                if (owner_ready_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DELIVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, held operands and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b1;
            r_q       <= {N{1'b0}};
            err_q     <= 1'b0;
            x_q       <= {N{1'b0}};
            m_q       <= {N{1'b0}};
            real_q    <= 1'b0;
            res_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            r_q       <= r_d;
            err_q     <= err_d;
            x_q       <= x_d;
            m_q       <= m_d;
            real_q    <= real_d;
            res_rdy_q <= res_rdy_d;
        end
    end

    // Output decode; everything below comes straight from registers except
    // the request grants, which are combinational by design.
    assign req_ready_a   = gnt_a_s;
    assign req_ready_b   = gnt_b_s;
    assign R             = r_q;
    assign res_err       = err_q;
    assign res_valid_a   = (state_q == ST_DELIVER) & ~owner_q;
    assign res_valid_b   = (state_q == ST_DELIVER) & owner_q;
    assign busy          = (state_q != ST_IDLE);
    assign owner         = owner_q;
    assign inv_rst       = inv_rst_q;
    assign inv_X         = x_q;
    assign inv_M         = m_q;
    assign inv_real      = real_q;
    assign inv_req_valid = (state_q == ST_ISSUE);
    assign inv_res_ready = res_rdy_q;

endmodule

// File: tb/tb_inv_arbiter.sv
// Self-checking bench for inv_arbiter: behavioural inverter model, per-port
// expected-result queues filled at accept time and a monitor that pops and
// compares whenever a result is consumed.
module tb_inv_arbiter;
    localparam int N = 255;
    localparam int W = N + 2;

    typedef struct packed {
        logic [N-1:0] r;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] X_a = '0, X_b = '0, M_a = '0, M_b = '0;
    logic         real_a = 1'b0, real_b = 1'b0;
    logic         req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic         req_ready_a, req_ready_b;
    logic [N-1:0] R;
    logic         res_err, res_valid_a, res_valid_b;
    logic         res_ready_a = 1'b0, res_ready_b = 1'b0;
    logic         busy, owner, inv_rst;
    logic [N-1:0] inv_X, inv_M;
    logic         inv_real, inv_req_valid, inv_res_ready;
    logic         m_rdy = 1'b0, m_busy = 1'b0, m_rv = 1'b0;
    logic [N-1:0] m_R = '0, m_sx = '0, m_sm = '0;
    logic         m_sr = 1'b0;
    int           m_cnt = 0;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   del_a_cyc = 0;
    bit   rr_mode = 1'b1;
    logic prev_irr = 1'b0;
    exp_t qa[$];
    exp_t qb[$];

    logic [N-1:0] P, K1, M2, M3;

    inv_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .X_a(X_a), .M_a(M_a), .real_a(real_a), .req_valid_a(req_valid_a), .req_ready_a(req_ready_a),
        .X_b(X_b), .M_b(M_b), .real_b(real_b), .req_valid_b(req_valid_b), .req_ready_b(req_ready_b),
        .R(R), .res_err(res_err), .res_valid_a(res_valid_a), .res_valid_b(res_valid_b),
        .res_ready_a(res_ready_a), .res_ready_b(res_ready_b),
        .busy(busy), .owner(owner), .inv_rst(inv_rst),
        .inv_X(inv_X), .inv_M(inv_M), .inv_real(inv_real), .inv_req_valid(inv_req_valid),
        .inv_req_ready(m_rdy), .inv_req_busy(m_busy), .inv_res_valid(m_rv),
        .inv_res_ready(inv_res_ready), .inv_R(m_R)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Modular inverse by binary extended Euclid (M odd, gcd(X,M)=1);
    // real=0 additionally multiplies by 2^N mod M.
    function automatic logic [N-1:0] ref_inv(input logic [N-1:0] x, input logic [N-1:0] m, input logic rl);
        logic [W-1:0] u, v, x1, x2, mm, r;
        if (x == '0) return '0;
        mm = W'(m); u = W'(x); v = mm; x1 = W'(1); x2 = W'(0);
        while (u != W'(1) && v != W'(1)) begin
            while (u[0] == 1'b0) begin
                u  = u >> 1;
                x1 = x1[0] ? ((x1 + mm) >> 1) : (x1 >> 1);
            end
            while (v[0] == 1'b0) begin
                v  = v >> 1;
                x2 = x2[0] ? ((x2 + mm) >> 1) : (x2 >> 1);
            end
            if (u >= v) begin
                u  = u - v;
                x1 = (x1 >= x2) ? (x1 - x2) : (x1 + mm - x2);
            end else begin
                v  = v - u;
                x2 = (x2 >= x1) ? (x2 - x1) : (x2 + mm - x1);
            end
        end
        r = (u == W'(1)) ? x1 : x2;
        r = r % mm;
        if (!rl) begin
            for (int i = 0; i < N; i++) begin
                r = r << 1;
                if (r >= mm) r = r - mm;
            end
        end
        return r[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_n();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[N-1:0];
    endfunction

    // Behavioural inverter: ready one cycle after seeing a request, random
    // latency, result computed from the operands held at completion time.
    always @(posedge clk) begin
        if (inv_rst) begin
            m_rdy <= 1'b0; m_busy <= 1'b0; m_rv <= 1'b0; m_cnt <= 0;
        end else begin
            m_rdy <= 1'b0;
            if (!m_busy && inv_req_valid && !m_rdy) m_rdy <= 1'b1;
            if (m_rdy && inv_req_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= int'($urandom_range(12, 1));
                m_sx <= inv_X; m_sm <= inv_M; m_sr <= inv_real;
            end
            if (m_busy && !m_rv) begin
                if (m_cnt == 0) begin
                    m_rv <= 1'b1;
                    m_R  <= ref_inv(inv_X, inv_M, inv_real);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (m_rv && inv_res_ready) begin
                m_rv <= 1'b0; m_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    // Result consumer readiness: always ready in directed phases, random otherwise.
    initial begin
        forever begin
            @(posedge clk); #2;
            res_ready_a = rr_mode ? 1'b1 : ($urandom_range(3, 0) != 0);
            res_ready_b = rr_mode ? 1'b1 : ($urandom_range(3, 0) != 0);
        end
    end

    // Monitor: pops expected results on consumption and watches invariants.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !inv_rst) begin
                if (res_valid_a | res_valid_b) check1("res_valid_exclusive", res_valid_a & res_valid_b, 1'b0);
                if (inv_res_ready) check1("inv_res_ready_pulse", prev_irr, 1'b0);
                if (m_busy) begin
                    check("held_inv_X", inv_X, m_sx);
                    check("held_inv_M", inv_M, m_sm);
                    check1("held_inv_real", inv_real, m_sr);
                end
                if (res_valid_a && res_ready_a) begin
                    if (qa.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_result_a: R=%0h err=%0b with nothing pending", R, res_err);
                    end else begin
                        e = qa.pop_front();
                        check("result_a_R", R, e.r);
                        check1("result_a_err", res_err, e.e);
                        del_a_cyc = cyc;
                    end
                end
                if (res_valid_b && res_ready_b) begin
                    if (qb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_result_b: R=%0h err=%0b with nothing pending", R, res_err);
                    end else begin
                        e = qb.pop_front();
                        check("result_b_R", R, e.r);
                        check1("result_b_err", res_err, e.e);
                    end
                end
            end
            prev_irr = inv_res_ready;
        end
    end

    task automatic junk(input bit p);
        if (p) begin X_b = rand_n(); M_b = rand_n(); real_b = $urandom_range(1, 0) != 0; end
        else   begin X_a = rand_n(); M_a = rand_n(); real_a = $urandom_range(1, 0) != 0; end
    endtask

    task automatic junk_cycles(input bit p, input int n);
        repeat (n) begin @(negedge clk); junk(p); end
    endtask

    // Present one request and wait for the grant; the expected result is
    // queued at accept. Returns at the negedge after the accepting edge.
    task automatic drive_req(input bit p, input logic [N-1:0] x, input logic [N-1:0] m,
                             input logic rl, input exp_t ex, output int acc);
        bit done;
        int t;
        @(negedge clk);
        if (p) begin X_b = x; M_b = m; real_b = rl; req_valid_b = 1'b1; end
        else   begin X_a = x; M_a = m; real_a = rl; req_valid_a = 1'b1; end
        done = 1'b0; t = 0; acc = -1;
        while (!done && t < 1000) begin
            #1;
            if (p ? req_ready_b : req_ready_a) begin
                acc = cyc;
                if (p) qb.push_back(ex); else qa.push_back(ex);
                done = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        if (p) req_valid_b = 1'b0; else req_valid_a = 1'b0;
        junk(p);
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout port %0d: no grant within %0d cycles", p, t);
        end
    endtask

    task automatic wait_drain(input int lim);
        int t;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0 || busy) && t < lim) begin
            @(negedge clk);
            if (!req_valid_a) junk(1'b0);
            if (!req_valid_b) junk(1'b1);
            t++;
        end
        if (t >= lim) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: pending a=%0d b=%0d busy=%0b", qa.size(), qb.size(), busy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0;
        #1;
        check1("rst_inv_rst", inv_rst, 1'b1);
        check1("rst_owner", owner, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check("rst_R", R, '0);
        check1("rst_res_err", res_err, 1'b0);
        check1("rst_res_valid_a", res_valid_a, 1'b0);
        check1("rst_res_valid_b", res_valid_b, 1'b0);
        check1("rst_req_ready_a", req_ready_a, 1'b0);
        check1("rst_req_ready_b", req_ready_b, 1'b0);
        check("rst_inv_X", inv_X, '0);
        check("rst_inv_M", inv_M, '0);
        check1("rst_inv_real", inv_real, 1'b0);
        check1("rst_inv_req_valid", inv_req_valid, 1'b0);
        check1("rst_inv_res_ready", inv_res_ready, 1'b0);
        qa.delete(); qb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; X_a = 2; M_a = P; real_a = 1'b1; req_valid_a = 1'b1;
        @(posedge clk); #1;
        check1("inv_rst_after_edge1", inv_rst, 1'b1);
        check1("no_grant_in_inv_rst", req_ready_a, 1'b0);
        @(posedge clk); #1;
        check1("inv_rst_after_edge2", inv_rst, 1'b0);
        req_valid_a = 1'b0;
    endtask

    initial begin
        int acc_a, acc_b, acc;
        int t;
        logic [N-1:0] x, m;
        logic rl;
        logic [N-1:0] mods [3];
        exp_t ex;

        P  = {N{1'b1}} - N'(18);
        K1 = {1'b0, {(N-1){1'b1}}} - N'(8);
        M2 = N'(1000003);
        M3 = {{(N-127){1'b0}}, {127{1'b1}}};
        mods[0] = P; mods[1] = M2; mods[2] = M3;

        repeat (3) @(negedge clk);
        do_reset();

        // single request on A, with issue-handshake timing
        drive_req(1'b0, N'(2), P, 1'b1, '{r: K1, e: 1'b0}, acc);
        check1("issue_after_edge0", inv_req_valid, 1'b1);
        check1("busy_after_accept", busy, 1'b1);
        @(negedge clk);
        check1("issue_after_edge1", inv_req_valid, 1'b1);
        @(negedge clk);
        check1("issue_dropped_edge2", inv_req_valid, 1'b0);
        wait_drain(200);
        check1("owner_after_a", owner, 1'b0);

        // Montgomery form on B
        drive_req(1'b1, N'(1), P, 1'b0, '{r: N'(19), e: 1'b0}, acc);
        wait_drain(200);
        check1("owner_after_b", owner, 1'b1);

        // tie after reset: A first, B in the IDLE cycle after A's delivery
        do_reset();
        fork
            drive_req(1'b0, N'(3), P, 1'b1, '{r: ref_inv(N'(3), P, 1'b1), e: 1'b0}, acc_a);
            drive_req(1'b1, N'(5), P, 1'b1, '{r: ref_inv(N'(5), P, 1'b1), e: 1'b0}, acc_b);
        join
        check1("tie_a_first", acc_a < acc_b, 1'b1);
        check("tie_b_after_delivery", N'(acc_b), N'(del_a_cyc + 1));
        wait_drain(200);
        check1("tie_owner_b", owner, 1'b1);
        fork
            drive_req(1'b0, N'(7), M2, 1'b0, '{r: ref_inv(N'(7), M2, 1'b0), e: 1'b0}, acc_a);
            drive_req(1'b1, N'(9), M2, 1'b1, '{r: ref_inv(N'(9), M2, 1'b1), e: 1'b0}, acc_b);
        join
        check1("tie2_a_first", acc_a < acc_b, 1'b1);
        wait_drain(200);

        // zero operand: local error, one cycle after accept, no inverter access
        drive_req(1'b0, '0, P, 1'b1, '{r: '0, e: 1'b1}, acc);
        check1("zero_res_valid_a", res_valid_a, 1'b1);
        check1("zero_res_err", res_err, 1'b1);
        check("zero_R", R, '0);
        check1("zero_no_issue", inv_req_valid, 1'b0);
        wait_drain(200);

        // operand stability: inputs scrambled every cycle after accept
        x = rand_n() % P; if (x == '0) x = N'(1);
        drive_req(1'b0, x, P, 1'b0, '{r: ref_inv(x, P, 1'b0), e: 1'b0}, acc);
        wait_drain(200);

        // randomized traffic on both ports
        rr_mode = 1'b0;
        fork
            for (int i = 0; i < 14; i++) begin
                logic [N-1:0] xa, ma; logic ra;
                junk_cycles(1'b0, int'($urandom_range(4, 0)));
                ma = mods[$urandom_range(2, 0)];
                xa = ($urandom_range(7, 0) == 0) ? '0 : rand_n() % ma;
                ra = $urandom_range(1, 0) != 0;
                drive_req(1'b0, xa, ma, ra, '{r: ref_inv(xa, ma, ra), e: (xa == '0)}, acc_a);
            end
            for (int j = 0; j < 14; j++) begin
                logic [N-1:0] xb, mb; logic rb;
                junk_cycles(1'b1, int'($urandom_range(4, 0)));
                mb = mods[$urandom_range(2, 0)];
                xb = ($urandom_range(7, 0) == 0) ? '0 : rand_n() % mb;
                rb = $urandom_range(1, 0) != 0;
                drive_req(1'b1, xb, mb, rb, '{r: ref_inv(xb, mb, rb), e: (xb == '0)}, acc_b);
            end
        join
        wait_drain(2000);
        rr_mode = 1'b1;

        // reset in the middle of WAIT, then a fresh request
        x = rand_n() % P; if (x == '0) x = N'(1);
        drive_req(1'b0, x, P, 1'b1, '{r: ref_inv(x, P, 1'b1), e: 1'b0}, acc);
        t = 0;
        while (!(m_busy && busy) && t < 100) begin @(negedge clk); t++; end
        check1("reached_wait", m_busy & busy, 1'b1);
        do_reset();
        drive_req(1'b0, N'(2), P, 1'b1, '{r: K1, e: 1'b0}, acc);
        wait_drain(200);

        check("final_pending_a", N'(qa.size()), '0);
        check("final_pending_b", N'(qb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inv_arbiter.md
# inv_arbiter

Two-port arbiter and sequencer that shares one `inv_montgomery` inverter between two independent requesters, such as a ladder-output normaliser and a test/debug port. It registers and holds each operand set for the whole inversion, drives the inverter's level-sensitive request and result handshakes, and routes the result back to the owning requester. It also generates the inverter's synchronous active-high reset from the system reset.

## Interface
- `N`, default 255: operand and result width in bits; passed through to the inverter.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `X_a`, `X_b`  in  N  operand to invert, range 1..M-1.
- `M_a`, `M_b`  in  N  modulus.
- `real_a`, `real_b`  in  1  1 gives R = X^-1 mod M; 0 gives R = X^-1·2^N mod M.
- `req_valid_a`, `req_valid_b`  in  1  request valid.
- `req_ready_a`, `req_ready_b`  out  1  request accepted when valid && ready.
- `R`  out  N  result, shared by both ports.
- `res_err`  out  1  qualifies `R`; set when the accepted X was 0.
- `res_valid_a`, `res_valid_b`  out  1  result valid for that port.
- `res_ready_a`, `res_ready_b`  in  1  result consumed when valid && ready.
- `busy`  out  1  state ≠ IDLE.
- `owner`  out  1  0 = A, 1 = B; last granted port.
- `inv_rst`  out  1  to the inverter's `rst`.
- `inv_X`, `inv_M`  out  N  held operands.
- `inv_real`  out  1  held operand, drives the inverter's `real_inverse`.
- `inv_req_valid`  out  1  drives the inverter's `req_valid`.
- `inv_req_ready`, `inv_req_busy`, `inv_res_valid`  in  1  inverter status.
- `inv_res_ready`  out  1  drives the inverter's `res_ready`.
- `inv_R`  in  N  inverter result.

## Operation
- States: IDLE, ISSUE, WAIT, DELIVER.
- **IDLE**
  - Grant is combinational. If exactly one `req_valid_x` is high, that port gets `req_ready_x`=1.
  - If both are high, grant goes to the port ≠ `owner` (round robin).
  - On handshake: X, M and real are captured into `inv_X`/`inv_M`/`inv_real`, and `owner` is set to the granted port.
  - If the captured X == 0: R←0, `res_err`←1, go to DELIVER with no inverter access. Otherwise go to ISSUE.
- **ISSUE**
  - `inv_req_valid`=1.
  - On the first cycle `inv_req_ready`=1: `inv_req_valid`←0, go to WAIT.
- **WAIT**
  - On `inv_res_valid`=1: R←`inv_R`, `res_err`←0, `inv_res_ready`←1 for exactly one cycle, go to DELIVER.
- **DELIVER**
  - `res_valid_owner`=1, the other port's `res_valid`=0.
  - R and `res_err` are held stable.
  - On `res_ready_owner`: go to IDLE. No request is accepted in that same cycle.
- `inv_X`, `inv_M` and `inv_real` must not change from capture until the next IDLE handshake, because the inverter samples M and real throughout the operation.
- `req_ready_x` is always 0 outside IDLE. Requests arriving while busy wait, with no loss and no reordering per port.
- `inv_req_valid` is never asserted while `inv_req_busy`=1 in IDLE; such a case is treated as a stale inverter and holds IDLE.

## Timing
- **Reset values**
  - All outputs 0 except `inv_rst`=1.
  - `owner`=1, so A wins the first tie.
  - State IDLE, R=0.
- **Reset sequencing**
  - `inv_rst` asserts asynchronously with `rst_n` low.
  - `inv_rst` deasserts synchronously on the 2nd rising edge after `rst_n` rises.
  - No grant is issued while `inv_rst`=1.
- **Mid-operation reset:** everything returns to reset values and the inverter is reset via `inv_rst`. No result is delivered and no pending `res_valid` survives.
- **Latency** (accept at edge 0):
  - `inv_req_valid` is high after edge 0.
  - The inverter raises `inv_req_ready` after edge 1.
  - The arbiter drops `inv_req_valid` at edge 2.
  - Result latency = inverter latency + 2 cycles: one to capture, then `res_valid` is visible the next cycle.
- **X == 0 path:** `res_valid` rises one cycle after accept.
- **Result handshake:** `inv_res_ready` is a single-cycle pulse. The inverter drops `inv_res_valid` one cycle later, and the arbiter ignores it outside WAIT.
- **Back-to-back:** minimum one IDLE cycle between delivery and the next grant.

## Test plan
- Single request: N=255, M=2^255-19, A sends X=2, real=1 → `res_valid_a` with R=2^254-9, `res_err`=0; `res_valid_b` stays 0.
- Montgomery form: B sends X=1, real=0, same M → `res_valid_b` with R=19.
- Tie: A and B both valid in the same cycle after reset → A served first, B accepted in the IDLE cycle after A's delivery, then `owner`=1. A repeated tie goes to A.
- Operand stability: change `X_a`/`M_a` on every cycle after accept → the result still matches the accepted values; `inv_X`/`inv_M` are constant through WAIT.
- Zero operand: A sends X=0 → R=0, `res_err`=1 one cycle after accept; `inv_req_valid` never rises.
- Reset mid-WAIT: pulse `rst_n` low → all outputs return to reset values, `inv_rst` releases 2 edges after `rst_n` rises, and a fresh request X=2 completes correctly.
